// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR decimator / FIFO slice.
package fir_pkg;

    localparam int N_DEF     = 8;
    localparam int DECIM_DEF = 4;
    localparam int DEPTH_DEF = 8;

    // Counter/pointer width for a modulus; never less than one bit so DECIM=1 still works.
    function automatic int addr_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/fir_decim_fifo_if.sv
// Sample-in / sample-out handshake bundle between the filter, the decimating FIFO and its consumer.
interface fir_decim_fifo_if
    import fir_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = addr_width(DEPTH);

    logic          in_valid;
    logic [N-1:0]  data_in;
    logic          out_ready;
    logic          out_valid;
    logic [N-1:0]  data_out;
    logic [AW:0]   fill_level;
    logic          overflow;

    modport master (
        output in_valid, data_in, out_ready,
        input  out_valid, data_out, fill_level, overflow
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output out_valid, data_out, fill_level, overflow
    );

endinterface

// File: rtl/fir_decim_fifo_chk.sv
// Invariants of the decimating FIFO, evaluated in simulation alongside the design.
module fir_decim_fifo_chk #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic         clk,
    input logic         reset,
    input logic         clear,
    input logic         pop,
    input logic         out_valid,
    input logic [N-1:0] data_out,
    input logic [AW:0]  fill_level,
    input logic         overflow
);

    a_fill_bound: assert property (@(posedge clk) disable iff (!reset)
        fill_level <= (AW+1)'(DEPTH));

    a_valid_matches_fill: assert property (@(posedge clk) disable iff (!reset)
        out_valid == (fill_level != {(AW+1){1'b0}}));

    a_empty_reads_zero: assert property (@(posedge clk) disable iff (!reset)
        !out_valid |-> (data_out == {N{1'b0}}));

    a_pop_needs_data: assert property (@(posedge clk) disable iff (!reset)
        pop |-> out_valid);

    a_clear_flushes: assert property (@(posedge clk) disable iff (!reset)
        clear |=> ((fill_level == {(AW+1){1'b0}}) && !overflow && !out_valid));

endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word, so data_out/out_valid
// come straight from flops and read as zero when the FIFO is empty.
module sync_fifo_fwft
    import fir_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wr_data,
    output logic [N-1:0] rd_data,
    output logic         rd_valid,
    output logic [AW:0]  fill_level,
    output logic         full
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_inc_s;
    logic [AW:0]   fill_r;
    logic [AW:0]   fill_nxt_s;
    logic [N-1:0]  head_r;
    logic [N-1:0]  head_nxt_s;
    logic          valid_r;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full_s    = (fill_r == DEPTH_W);
    assign pop_ok_s  = pop && valid_r && !clear;
    assign push_ok_s = push && !clear && (!full_s || pop_ok_s);
    assign rd_inc_s  = rd_ptr_r + AW'(1);

    // Occupancy after this edge.
    always_comb begin
        fill_nxt_s = fill_r;
        if (clear) begin
            fill_nxt_s = {(AW+1){1'b0}};
        end else if (push_ok_s && !pop_ok_s) begin
            fill_nxt_s = fill_r + (AW+1)'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            fill_nxt_s = fill_r - (AW+1)'(1);
        end else begin
            fill_nxt_s = fill_r;
        end
    end

    // Head word after this edge: bypass the incoming sample when it becomes the only entry.
    always_comb begin
        head_nxt_s = head_r;
        if (clear || (fill_nxt_s == {(AW+1){1'b0}})) begin
            head_nxt_s = {N{1'b0}};
        end else if (pop_ok_s) begin
            head_nxt_s = (fill_r == (AW+1)'(1)) ? wr_data : mem_r[rd_inc_s];
        end else if (!valid_r) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Read/write pointers, wrapping modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_inc_s;
            end
        end
    end

    // Registered occupancy and output word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_r  <= {(AW+1){1'b0}};
            head_r  <= {N{1'b0}};
            valid_r <= 1'b0;
        end else begin
            fill_r  <= fill_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (fill_nxt_s != {(AW+1){1'b0}});
        end
    end

    assign rd_data    = head_r;
    assign rd_valid   = valid_r;
    assign fill_level = fill_r;
    assign full       = full_s;

endmodule

// File: rtl/fir_decim_fifo.sv
// Keeps one of every DECIM filter samples, buffers kept samples in an FWFT FIFO
// and raises a sticky overflow flag when a kept sample finds the FIFO full.
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic             clk,
    input logic             reset,
    input logic             clear,
    fir_decim_fifo_if.slave bus
);

    localparam int AW = addr_width(DEPTH);
    localparam int PW = addr_width(DECIM);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

    logic [PW-1:0] phase_r;
    logic [PW-1:0] phase_nxt_s;
    logic          kept_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          full_s;
    logic          valid_s;
    logic          overflow_r;
    logic [N-1:0]  data_s;
    logic [AW:0]   fill_s;

    assign kept_s = bus.in_valid && (phase_r == {PW{1'b0}}) && !clear;
    assign pop_s  = valid_s && bus.out_ready && !clear;
    assign push_s = kept_s && (!full_s || pop_s);
    assign drop_s = kept_s && full_s && !pop_s;

    // Decimation phase advances only on valid samples, drops included.
    always_comb begin
        phase_nxt_s = phase_r;
        if (clear) begin
            phase_nxt_s = {PW{1'b0}};
        end else if (bus.in_valid) begin
            phase_nxt_s = (phase_r == PHASE_LAST) ? {PW{1'b0}} : (phase_r + PW'(1));
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= {PW{1'b0}};
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Sticky overflow: only reset or clear can lower it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    sync_fifo_fwft #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (push_s),
        .pop        (pop_s),
        .wr_data    (bus.data_in),
        .rd_data    (data_s),
        .rd_valid   (valid_s),
        .fill_level (fill_s),
        .full       (full_s)
    );

    fir_decim_fifo_chk #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .pop        (pop_s),
        .out_valid  (valid_s),
        .data_out   (data_s),
        .fill_level (fill_s),
        .overflow   (overflow_r)
    );

    assign bus.out_valid  = valid_s;
    assign bus.data_out   = data_s;
    assign bus.fill_level = fill_s;
    assign bus.overflow   = overflow_r;

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Downstream stage of the 8-bit weighted moving-average FIR; consumes its registered data_out stream.
- Decimates the filtered samples by DECIM and buffers the kept samples in a small first-word-fall-through FIFO.
- Presents the buffered samples to the consumer over a valid/ready handshake.
- Flags lost samples with a sticky overflow bit.

Parameters:
- N, 8, sample width; matches the filter's N.
- DECIM, 4, decimation factor; keep 1 of every DECIM input samples (DECIM >= 1).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AW, log2(DEPTH), derived local constant; pointer width, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush.
- in_valid  input  1  filter sample strobe; tied high when the filter runs every cycle.
- data_in  input  N  filter output sample.
- out_ready  input  1  consumer can take a sample this cycle.
- out_valid  output  1  FIFO non-empty; data_out holds a valid sample.
- data_out  output  N  oldest buffered sample.
- fill_level  output  AW+1  number of buffered samples, 0..DEPTH.
- overflow  output  1  sticky; a kept sample was dropped.

Behaviour:
- Reset (reset=0, async): out_valid=0, data_out=0, fill_level=0, overflow=0. Phase counter, write pointer and read pointer all go to 0. FIFO memory contents are don't-care.
- Phase counter: counts 0..DECIM-1. It advances only on cycles with in_valid=1 and wraps from DECIM-1 to 0.
- Keep rule: a sample is kept when in_valid=1 and phase==0.
  - The first valid sample after reset or clear is kept.
  - DECIM=1 keeps every valid sample.
- push = kept && (fill_level<DEPTH || pop).
  - A full FIFO accepts a new sample in the same cycle it is popped.
- pop = out_valid && out_ready.
- Drop: kept && fill_level==DEPTH && !pop. The sample is discarded and overflow is set to 1.
  - overflow clears only on reset or clear.
  - The phase counter advances normally on a drop.
- FWFT output: data_out = mem[rd_ptr] when out_valid=1, and 0 when empty. out_valid = (fill_level != 0).
  - A sample pushed at rising edge k shows on data_out/out_valid after edge k (1-cycle latency).
  - The same sample can be popped in the cycle following edge k.
- fill_level per edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together.
- Pointers are AW bits wide and wrap modulo DEPTH.
- Empty + kept: push only. Pop is impossible because out_valid=0.
- out_ready with out_valid=0 has no effect.
- clear=1 (sync, highest priority after reset):
  - Next edge: pointers=0, fill_level=0, phase=0, overflow=0, out_valid=0.
  - Same-cycle in_valid and out_ready are ignored.
- Reset asserted mid-operation: immediate return to reset values; buffered samples are lost.
- Arithmetic: samples are stored unmodified; no truncation.

Decomposition:
- Shared package fir_pkg holds:
  - default N = 8;
  - default DEPTH = 8 and DECIM = 4;
  - a clog2-based helper for AW.
- One sub-module, sync_fifo_fwft (params N, DEPTH), containing memory, pointers, fill_level, push/pop.
- The top level holds the phase counter, keep/drop logic and the overflow flag.

Test Plan:
- Reset then in_valid=1 with data_in = 1,2,3,...,16 and out_ready=1 -> samples 1,5,9,13 appear, each out_valid one cycle after acceptance. fill_level never exceeds 1. overflow=0.
- DECIM=4, out_ready=0, 40 ramped samples -> samples 1,5,...,29 fill the FIFO (fill_level=8). Sample 33 is dropped and overflow=1. Raising out_ready drains 1,5,...,29 in order.
- Full FIFO with out_ready=1 on a keep cycle -> one pop and one push. fill_level stays at 8, overflow stays 0, and the new sample lands last.
- in_valid toggling 1,0,1,0 with DECIM=2 -> phase advances only on valid cycles; kept samples are the 1st, 3rd, 5th valid samples.
- clear=1 with fill_level=5, in_valid=1, out_ready=1 -> next cycle fill_level=0, out_valid=0, overflow=0. The following valid sample is kept.
- reset driven low between edges with fill_level=3 -> out_valid, data_out and fill_level drop to 0 without waiting for a clock edge.
